// File: rtl/psu_mon_pkg.sv
// Shared constants and helpers for the PSU status monitor.
// The window and fail counter widths follow from the default constants.
package psu_mon_pkg;

  localparam int DEB_STROBES  = 3;
  localparam int WIN_STROBES  = 64;
  localparam int TACH_MIN     = 20;
  localparam int TACH_MAX     = 200;
  localparam int FAIL_WINDOWS = 2;

  localparam int WIN_W  = $clog2(WIN_STROBES);
  localparam int FAIL_W = $clog2(FAIL_WINDOWS + 1);

  typedef enum logic [1:0] {
    TACH_IN_RANGE = 2'd0,
    TACH_BELOW    = 2'd1,
    TACH_ABOVE    = 2'd2
  } tach_class_e;

  // Classify one closed window's edge count against the tach limits.
  function automatic tach_class_e classify_tach(input logic [7:0] count);
    tach_class_e cls;
    cls = TACH_IN_RANGE;
    if (count < 8'(TACH_MIN)) begin
      cls = TACH_BELOW;
    end else if (count > 8'(TACH_MAX)) begin
      cls = TACH_ABOVE;
    end
    return cls;
  endfunction

endpackage

// File: rtl/psu_debounce.sv
// One-bit synchroniser plus strobe-based debouncer.
// The debounced level only follows the synchronised input after it has
// differed on DEB_STROBES consecutive strobes.
module psu_debounce #(
  parameter int DEB_STROBES = psu_mon_pkg::DEB_STROBES
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic raw_in,
  output logic deb_out
);

  localparam int CNT_W = $clog2(DEB_STROBES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two-stage synchroniser and debounce run counter.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    if (strobe) begin
      if (sync2_q != deb_q) begin
        if (cnt_q == CNT_W'(DEB_STROBES - 1)) begin
          deb_d = sync2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_out = deb_q;

endmodule

// File: rtl/psu_status_monitor.sv
// PSU/fan status producer: debounced present/power-OK, overall supply
// health and windowed PSU1 tach rate with qualified low/high flags.
module psu_status_monitor
  import psu_mon_pkg::*;
(
  input  logic       SlowClock,
  input  logic       Reset,
  input  logic       Strobe16ms,
  input  logic       DualPS,
  input  logic [2:1] PSU_PRSNT_N,
  input  logic [2:1] PSU_PWROK,
  input  logic       PSU1_TACH,
  output logic [2:1] PsuPresent,
  output logic [2:1] PsuPwrOk,
  output logic       PowerSupplyOK,
  output logic       PSU1_Tach_Low,
  output logic       PSU1_Tach_High,
  output logic [7:0] TachCount,
  output logic       StatusValid
);

  if (WIN_STROBES <= DEB_STROBES) begin : g_param_check
    $error("psu_status_monitor: WIN_STROBES must exceed DEB_STROBES");
  end

  for (genvar i = 1; i <= 2; i++) begin : g_psu
    psu_debounce #(.DEB_STROBES(DEB_STROBES)) u_prsnt (
      .clk    (SlowClock),
      .reset  (Reset),
      .strobe (Strobe16ms),
      .raw_in (~PSU_PRSNT_N[i]),
      .deb_out(PsuPresent[i])
    );
    psu_debounce #(.DEB_STROBES(DEB_STROBES)) u_pwrok (
      .clk    (SlowClock),
      .reset  (Reset),
      .strobe (Strobe16ms),
      .raw_in (PSU_PWROK[i]),
      .deb_out(PsuPwrOk[i])
    );
  end

  logic              tach_s1_q, tach_s1_d;
  logic              tach_s2_q, tach_s2_d;
  logic              tach_prev_q, tach_prev_d;
  logic [7:0]        edge_cnt_q, edge_cnt_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [7:0]        tach_count_q, tach_count_d;
  logic [FAIL_W-1:0] low_fail_q, low_fail_d;
  logic [FAIL_W-1:0] high_fail_q, high_fail_d;
  logic              low_flag_q, low_flag_d;
  logic              high_flag_q, high_flag_d;
  logic              pso_q, pso_d;
  logic              valid_q, valid_d;

  logic              tach_edge;
  logic              win_close;
  logic [7:0]        edge_sum;

  assign tach_edge = tach_s2_q & ~tach_prev_q;
  assign win_close = Strobe16ms && (win_cnt_q == WIN_W'(WIN_STROBES - 1));
  assign edge_sum  = (edge_cnt_q == 8'hFF) ? 8'hFF : edge_cnt_q + {7'd0, tach_edge};

  // Tach synchroniser, saturating edge counter and measurement window.
  always_comb begin
    tach_s1_d    = PSU1_TACH;
    tach_s2_d    = tach_s1_q;
    tach_prev_d  = tach_s2_q;
    edge_cnt_d   = edge_sum;
    win_cnt_d    = win_cnt_q;
    tach_count_d = tach_count_q;
    valid_d      = valid_q;
    if (Strobe16ms) begin
      win_cnt_d = win_close ? '0 : win_cnt_q + WIN_W'(1);
    end
    if (win_close) begin
      tach_count_d = edge_sum;
      edge_cnt_d   = '0;
      valid_d      = 1'b1;
    end
  end

  // Per-window tach qualification, flags and overall supply health.
  always_comb begin
    low_fail_d  = low_fail_q;
    high_fail_d = high_fail_q;
    if (win_close) begin
      case (classify_tach(edge_sum))
        TACH_BELOW: begin
          low_fail_d  = (low_fail_q == FAIL_W'(FAIL_WINDOWS)) ? low_fail_q
                                                              : low_fail_q + FAIL_W'(1);
          high_fail_d = '0;
        end
        TACH_ABOVE: begin
          high_fail_d = (high_fail_q == FAIL_W'(FAIL_WINDOWS)) ? high_fail_q
                                                               : high_fail_q + FAIL_W'(1);
          low_fail_d  = '0;
        end
        default: begin
          low_fail_d  = '0;
          high_fail_d = '0;
        end
      endcase
    end
    if (!PsuPresent[1]) begin
      low_fail_d  = '0;
      high_fail_d = '0;
    end
    low_flag_d  = PsuPresent[1] && (low_fail_q >= FAIL_W'(FAIL_WINDOWS));
    high_flag_d = PsuPresent[1] && (high_fail_q >= FAIL_W'(FAIL_WINDOWS));
    if (DualPS) begin
      pso_d = (PsuPresent[1] | PsuPresent[2]) &
              (~PsuPresent[1] | PsuPwrOk[1]) &
              (~PsuPresent[2] | PsuPwrOk[2]);
    end else begin
      pso_d = PsuPresent[1] & PsuPwrOk[1];
    end
  end

  // State register; reset wins over every other event.
  always_ff @(posedge SlowClock) begin
    if (Reset) begin
      tach_s1_q    <= 1'b0;
      tach_s2_q    <= 1'b0;
      tach_prev_q  <= 1'b0;
      edge_cnt_q   <= '0;
      win_cnt_q    <= '0;
      tach_count_q <= '0;
      low_fail_q   <= '0;
      high_fail_q  <= '0;
      low_flag_q   <= 1'b0;
      high_flag_q  <= 1'b0;
      pso_q        <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      tach_s1_q    <= tach_s1_d;
      tach_s2_q    <= tach_s2_d;
      tach_prev_q  <= tach_prev_d;
      edge_cnt_q   <= edge_cnt_d;
      win_cnt_q    <= win_cnt_d;
      tach_count_q <= tach_count_d;
      low_fail_q   <= low_fail_d;
      high_fail_q  <= high_fail_d;
      low_flag_q   <= low_flag_d;
      high_flag_q  <= high_flag_d;
      pso_q        <= pso_d;
      valid_q      <= valid_d;
    end
  end

  assign PowerSupplyOK  = pso_q;
  assign PSU1_Tach_Low  = low_flag_q;
  assign PSU1_Tach_High = high_flag_q;
  assign TachCount      = tach_count_q;
  assign StatusValid    = valid_q;

endmodule
